// File: rtl/axil_mem_ctrl.sv
// axil_mem_ctrl: registered AXI4-Lite slave in front of a single-port SRAM
// with one-cycle read latency. Reads and writes are arbitrated round-robin,
// one transaction is outstanding at most, and R/B responses are held until
// the master accepts them.
//
// Optional feature macro: AXIL_MEM_CTRL_RANGE_CHECK_EN
//   defined   -> addresses beyond the memory depth get SLVERR, no SRAM access
//   undefined -> upper address bits are ignored (index wraps), always OKAY

package soc_pkg;
    localparam int unsigned AXIL_ADDR_W = 18;
    localparam int unsigned AXIL_DATA_W = 64;

    typedef struct packed {
        logic [AXIL_ADDR_W-1:0] addr;
        logic [2:0]             prot;
    } axil_ax_t;

    typedef struct packed {
        logic [AXIL_DATA_W-1:0]   data;
        logic [AXIL_DATA_W/8-1:0] strb;
    } axil_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axil_b_t;

    typedef struct packed {
        logic [AXIL_DATA_W-1:0] data;
        logic [1:0]             resp;
    } axil_r_t;

    typedef struct packed {
        axil_ax_t aw;
        logic     aw_valid;
        axil_w_t  w;
        logic     w_valid;
        logic     b_ready;
        axil_ax_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axil_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axil_b_t b;
        logic    b_valid;
        logic    ar_ready;
        axil_r_t r;
        logic    r_valid;
    } axil_resp_t;
endpackage

module axil_mem_ctrl #(
    parameter type         req_t      = soc_pkg::axil_req_t,
    parameter type         resp_t     = soc_pkg::axil_resp_t,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_DEPTH  = 1024,
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH),
    localparam int unsigned OFF_W     = $clog2(DATA_WIDTH / 8),
    localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  req_t                  req_i,
    output resp_t                 resp_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [IDX_W-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_W-1:0]       mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RCAP  = 2'd1,
        ST_RRESP = 2'd2,
        ST_BRESP = 2'd3
    } state_e;

    state_e                state_r;
    state_e                state_nxt_s;
    logic                  prio_r;        // 0: read wins a tie, 1: write wins
    logic                  post_rst_r;    // blocks grants in the cycle after reset
    logic                  rd_err_r;      // granted read was out of range
    logic [DATA_WIDTH-1:0] r_data_r;
    logic [1:0]            r_resp_r;
    logic [1:0]            b_resp_r;

    logic                  idle_open_s;
    logic                  wr_elig_s;
    logic                  rd_elig_s;
    logic                  grant_wr_s;
    logic                  grant_rd_s;
    logic [ADDR_WIDTH-1:0] aw_addr_s;
    logic [ADDR_WIDTH-1:0] ar_addr_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic                  wr_oor_s;
    logic                  rd_oor_s;
    logic                  unused_s;

    assign aw_addr_s = req_i.aw.addr;
    assign ar_addr_s = req_i.ar.addr;
    assign wr_idx_s  = aw_addr_s[OFF_W+IDX_W-1:OFF_W];
    assign rd_idx_s  = ar_addr_s[OFF_W+IDX_W-1:OFF_W];

`ifdef AXIL_MEM_CTRL_RANGE_CHECK_EN
    // Any set bit above the word index means the access misses the memory.
    assign wr_oor_s = |(aw_addr_s >> (OFF_W + IDX_W));
    assign rd_oor_s = |(ar_addr_s >> (OFF_W + IDX_W));
`else
    // Upper bits are ignored so the index simply wraps around the depth.
    assign wr_oor_s = 1'b0;
    assign rd_oor_s = 1'b0;
`endif

    // Protection bits and byte-offset bits carry no meaning for this memory.
    assign unused_s = ^{req_i.aw.prot, req_i.ar.prot, aw_addr_s, ar_addr_s};

    // Eligibility and round-robin tie break; grants only in an open IDLE cycle.
    always_comb begin
        idle_open_s = (state_r == ST_IDLE) && !srst_i && !post_rst_r;
        wr_elig_s   = idle_open_s && req_i.aw_valid && req_i.w_valid;
        rd_elig_s   = idle_open_s && req_i.ar_valid;
        grant_wr_s  = 1'b0;
        grant_rd_s  = 1'b0;
        if (wr_elig_s && rd_elig_s) begin
            grant_wr_s = prio_r;
            grant_rd_s = !prio_r;
        end else begin
            grant_wr_s = wr_elig_s;
            grant_rd_s = rd_elig_s;
        end
    end

    // SRAM strobe, address and data driven only in the granting cycle.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (grant_wr_s) begin
            mem_req_o   = !wr_oor_s;
            mem_we_o    = !wr_oor_s;
            mem_addr_o  = wr_idx_s;
            mem_wdata_o = req_i.w.data;
            mem_be_o    = req_i.w.strb;
        end else if (grant_rd_s) begin
            mem_req_o  = !rd_oor_s;
            mem_addr_o = rd_idx_s;
        end else begin
            mem_req_o = 1'b0;
        end
    end

    // Next-state decode; responses leave only once the master has taken them.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_wr_s) begin
                    state_nxt_s = ST_BRESP;
                end else if (grant_rd_s) begin
                    state_nxt_s = ST_RCAP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RCAP: begin
                state_nxt_s = ST_RRESP;
            end
            ST_RRESP: begin
                if (req_i.r_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RRESP;
                end
            end
            ST_BRESP: begin
                if (req_i.b_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BRESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Response channel assembly; valids come from state, never from readies.
    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = grant_wr_s;
        resp_o.w_ready  = grant_wr_s;
        resp_o.ar_ready = grant_rd_s;
        resp_o.b_valid  = (state_r == ST_BRESP) && !srst_i;
        resp_o.b.resp   = b_resp_r;
        resp_o.r_valid  = (state_r == ST_RRESP) && !srst_i;
        resp_o.r.data   = r_data_r;
        resp_o.r.resp   = r_resp_r;
    end

    // State register, post-reset grant blocker and arbitration pointer.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r    <= ST_IDLE;
            post_rst_r <= 1'b1;
            prio_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            post_rst_r <= 1'b0;
            if (grant_wr_s) begin
                prio_r <= 1'b0;
            end else if (grant_rd_s) begin
                prio_r <= 1'b1;
            end
        end
    end

    // Response payload registers: B status at write grant, R data in RCAP.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rd_err_r <= 1'b0;
            b_resp_r <= RESP_OKAY;
            r_resp_r <= RESP_OKAY;
            r_data_r <= '0;
        end else begin
            if (grant_wr_s) begin
                b_resp_r <= wr_oor_s ? RESP_SLVERR : RESP_OKAY;
            end
            if (grant_rd_s) begin
                rd_err_r <= rd_oor_s;
            end
            if (state_r == ST_RCAP) begin
                r_data_r <= rd_err_r ? '0 : mem_rdata_i;
                r_resp_r <= rd_err_r ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_ctrl.sv
// Self-checking bench for axil_mem_ctrl: directed scenarios followed by a
// randomized read/write mix, checked against a word-array memory model.
module tb_axil_mem_ctrl;
    import soc_pkg::*;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 18;
    localparam int unsigned DEPTH = 1024;

`ifdef AXIL_MEM_CTRL_RANGE_CHECK_EN
    localparam bit RANGE_CK = 1'b1;
`else
    localparam bit RANGE_CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        srst;
    axil_req_t   req;
    axil_resp_t  resp;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata = 64'h0;

    logic [63:0] sram    [DEPTH] = '{default: 64'h0};
    logic [63:0] ref_mem [DEPTH] = '{default: 64'h0};

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axil_mem_ctrl #(
        .req_t      (axil_req_t),
        .resp_t     (axil_resp_t),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .req_i       (req),
        .resp_o      (resp),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata)
    );

    // Synchronous SRAM with byte enables and one-cycle read latency.
    always @(posedge clk) begin : sram_model
        logic [63:0] tmp;
        if (mem_req) begin
            if (mem_we) begin
                tmp = sram[mem_addr];
                for (int b = 0; b < 8; b++) begin
                    if (mem_be[b]) tmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
                end
                sram[mem_addr] <= tmp;
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    function automatic int unsigned exp_idx(input logic [17:0] a);
        return (32'(a) / 8) % DEPTH;
    endfunction

    function automatic bit range_err(input logic [17:0] a);
        return RANGE_CK && ((32'(a) / (8 * DEPTH)) != 0);
    endfunction

    function automatic void model_write(input int unsigned idx, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) begin
            if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input bit is_wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (is_wr ? resp.aw_ready : resp.ar_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ar_ready"},  64'(resp.ar_ready), 64'd0);
        chk({tag, "_aw_ready"},  64'(resp.aw_ready), 64'd0);
        chk({tag, "_w_ready"},   64'(resp.w_ready),  64'd0);
        chk({tag, "_r_valid"},   64'(resp.r_valid),  64'd0);
        chk({tag, "_b_valid"},   64'(resp.b_valid),  64'd0);
        chk({tag, "_mem_req"},   64'(mem_req),       64'd0);
        chk({tag, "_mem_we"},    64'(mem_we),        64'd0);
        chk({tag, "_mem_addr"},  64'(mem_addr),      64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,          64'd0);
        chk({tag, "_mem_be"},    64'(mem_be),        64'd0);
        chk({tag, "_r_data"},    resp.r.data,        64'd0);
    endtask

    task automatic axil_write(input logic [17:0] addr, input logic [63:0] data, input logic [7:0] strb);
        bit ok;
        bit oor;
        int unsigned idx;
        idx = exp_idx(addr);
        oor = range_err(addr);
        req.aw.addr  = addr;
        req.aw.prot  = 3'($urandom);
        req.aw_valid = 1'b1;
        req.w.data   = data;
        req.w.strb   = strb;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b1;
        wait_grant(1'b1, ok);
        chk("wr_handshake", 64'(ok), 64'd1);
        if (ok) begin
            chk("wr_w_ready", 64'(resp.w_ready), 64'd1);
            chk("wr_mem_req", 64'(mem_req), 64'(!oor));
            chk("wr_mem_we",  64'(mem_we),  64'(!oor));
            if (!oor) begin
                chk("wr_mem_addr",  64'(mem_addr), 64'(idx));
                chk("wr_mem_wdata", mem_wdata,     data);
                chk("wr_mem_be",    64'(mem_be),   64'(strb));
            end
            @(posedge clk); #1;
            req.aw_valid = 1'b0;
            req.w_valid  = 1'b0;
            @(negedge clk);
            chk("wr_b_valid", 64'(resp.b_valid), 64'd1);
            chk("wr_b_resp",  64'(resp.b.resp),  oor ? 64'd2 : 64'd0);
            @(posedge clk); #1;
            if (!oor) model_write(idx, data, strb);
        end else begin
            req.aw_valid = 1'b0;
            req.w_valid  = 1'b0;
        end
    endtask

    task automatic axil_read(input logic [17:0] addr, input int hold);
        bit ok;
        bit oor;
        int unsigned idx;
        logic [63:0] exp_d;
        idx   = exp_idx(addr);
        oor   = range_err(addr);
        exp_d = oor ? 64'h0 : ref_mem[idx];
        req.ar.addr  = addr;
        req.ar.prot  = 3'($urandom);
        req.ar_valid = 1'b1;
        req.r_ready  = (hold == 0);
        wait_grant(1'b0, ok);
        chk("rd_handshake", 64'(ok), 64'd1);
        if (ok) begin
            chk("rd_mem_req", 64'(mem_req), 64'(!oor));
            chk("rd_mem_we",  64'(mem_we),  64'd0);
            if (!oor) chk("rd_mem_addr", 64'(mem_addr), 64'(idx));
            @(posedge clk); #1;
            req.ar_valid = 1'b0;
            @(negedge clk);
            chk("rd_t1_r_valid", 64'(resp.r_valid), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rd_r_valid", 64'(resp.r_valid), 64'd1);
            chk("rd_r_data",  resp.r.data,       exp_d);
            chk("rd_r_resp",  64'(resp.r.resp),  oor ? 64'd2 : 64'd0);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                req.ar_valid = 1'b1;
                req.aw_valid = 1'b1;
                req.w_valid  = 1'b1;
                @(negedge clk);
                chk("hold_r_valid",  64'(resp.r_valid),  64'd1);
                chk("hold_r_data",   resp.r.data,        exp_d);
                chk("hold_ar_ready", 64'(resp.ar_ready), 64'd0);
                chk("hold_aw_ready", 64'(resp.aw_ready), 64'd0);
                chk("hold_mem_req",  64'(mem_req),       64'd0);
            end
            if (hold > 0) begin
                @(posedge clk); #1;
                req.ar_valid = 1'b0;
                req.aw_valid = 1'b0;
                req.w_valid  = 1'b0;
                req.r_ready  = 1'b1;
                @(negedge clk);
                chk("hold_end_r_valid", 64'(resp.r_valid), 64'd1);
            end
            @(posedge clk); #1;
        end else begin
            req.ar_valid = 1'b0;
        end
    endtask

    // Guard against a hung handshake sequence.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d0;
        logic [17:0] addr;
        bit          ok;
        int unsigned idx_set [8] = '{0, 1, 3, 5, 100, 511, 512, 1023};

        d0 = 64'h0123_4567_89AB_CDEF;

        // Reset with every request valid: nothing may be granted.
        srst         = 1'b1;
        req          = '0;
        req.ar.addr  = 18'h18;
        req.ar_valid = 1'b1;
        req.aw.addr  = 18'h0;
        req.aw_valid = 1'b1;
        req.w.data   = d0;
        req.w.strb   = 8'hFF;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b1;
        req.r_ready  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_quiet("rst");
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        check_quiet("post_rst");

        // Simultaneous AR and AW/W out of reset: read first.
        @(posedge clk); #1;
        @(negedge clk);
        chk("arb1_ar_ready", 64'(resp.ar_ready), 64'd1);
        chk("arb1_aw_ready", 64'(resp.aw_ready), 64'd0);
        chk("arb1_mem_we",   64'(mem_we),        64'd0);
        chk("arb1_mem_addr", 64'(mem_addr),      64'(exp_idx(18'h18)));
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        @(negedge clk);
        chk("arb1_rcap_aw_ready", 64'(resp.aw_ready), 64'd0);
        chk("arb1_rcap_r_valid",  64'(resp.r_valid),  64'd0);
        @(posedge clk); #1;
        req.ar.addr  = 18'h0;
        req.ar_valid = 1'b1;
        @(negedge clk);
        chk("arb1_r_valid", 64'(resp.r_valid), 64'd1);
        chk("arb1_r_data",  resp.r.data,       ref_mem[exp_idx(18'h18)]);
        // Pending write plus a new read: write now wins.
        @(posedge clk); #1;
        @(negedge clk);
        chk("arb2_aw_ready", 64'(resp.aw_ready), 64'd1);
        chk("arb2_ar_ready", 64'(resp.ar_ready), 64'd0);
        chk("arb2_mem_we",   64'(mem_we),        64'd1);
        chk("arb2_mem_addr", 64'(mem_addr),      64'd0);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        model_write(exp_idx(18'h0), d0, 8'hFF);
        @(negedge clk);
        chk("arb2_b_valid",  64'(resp.b_valid),  64'd1);
        chk("arb2_ar_ready", 64'(resp.ar_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("arb3_ar_ready", 64'(resp.ar_ready), 64'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("arb3_r_data", resp.r.data, ref_mem[0]);
        @(posedge clk); #1;

        // Full-strobe write then read back, then a partial-strobe overwrite.
        axil_write(18'h18, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        axil_read(18'h18, 0);
        axil_write(18'h18, 64'h11111111_22222222, 8'h0F);
        axil_read(18'h18, 5);

        // Address one past the end of memory.
        axil_read(18'h2000, 0);
        axil_write(18'h2008, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        axil_read(18'h0008, 0);

        // Reset while a B response is waiting.
        req.aw.addr  = 18'h40;
        req.aw_valid = 1'b1;
        req.w.data   = 64'h7777_8888_9999_AAAA;
        req.w.strb   = 8'h3C;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b0;
        wait_grant(1'b1, ok);
        chk("srst_wr_handshake", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        if (ok) model_write(exp_idx(18'h40), 64'h7777_8888_9999_AAAA, 8'h3C);
        @(negedge clk);
        chk("srst_b_valid_before", 64'(resp.b_valid), 64'd1);
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst        = 1'b0;
        req.b_ready = 1'b1;
        @(negedge clk);
        chk("srst_b_valid_after", 64'(resp.b_valid), 64'd0);
        @(posedge clk); #1;
        axil_write(18'h40, 64'h1234_5678_9ABC_DEF0, 8'hF0);
        axil_read(18'h40, 0);

        // Randomized mix over a small set of indices, some with upper bits set.
        for (int n = 0; n < 60; n++) begin
            addr = 18'(idx_set[$urandom_range(0, 7)] * 8 + $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) addr[17:13] = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 1) == 0) begin
                axil_write(addr, {$urandom, $urandom}, 8'($urandom));
            end else begin
                axil_read(addr, $urandom_range(0, 2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_mem_ctrl.md
# axil_mem_ctrl

AXI4-Lite slave that serves single-beat reads and writes from a synchronous single-port SRAM with one-cycle read latency. It sits directly downstream of the `axi_to_axi_lite` converter in the on-chip RAM path and replaces the combinational handshake glue with a registered controller. The controller arbitrates round-robin between reads and writes, holds responses under back-pressure, and optionally range-checks addresses against the memory depth.

## Interface
- `req_t`, `soc_pkg::axil_req_t`: AXI-Lite request struct (aw, w, ar channels plus valids, `b_ready`, `r_ready`).
- `resp_t`, `soc_pkg::axil_resp_t`: AXI-Lite response struct (readies, b, r channels plus valids).
- `ADDR_WIDTH`, 18: byte-address width of `req_i.aw.addr` / `req_i.ar.addr`.
- `DATA_WIDTH`, 64: data width; must equal `$bits(req_i.w.data)`; power of two, at least 32.
- `MEM_DEPTH`, 1024: SRAM words; power of two. `IDX_W = $clog2(MEM_DEPTH)`, `OFF_W = $clog2(DATA_WIDTH/8)`.
- `clk_i`, input, 1: clock; all logic is rising-edge.
- `srst_i`, input, 1: reset, synchronous, active-high.
- `req_i`, input, `req_t`: AXI-Lite request.
- `resp_o`, output, `resp_t`: AXI-Lite response.
- `mem_req_o`, output, 1: SRAM access strobe.
- `mem_we_o`, output, 1: write enable; valid only with `mem_req_o`.
- `mem_addr_o`, output, `IDX_W`: word index.
- `mem_wdata_o`, output, `DATA_WIDTH`: write data.
- `mem_be_o`, output, `DATA_WIDTH/8`: byte enables (copy of `w.strb`).
- `mem_rdata_i`, input, `DATA_WIDTH`: read data, valid the cycle after a read strobe.

## Operation
- FSM states: IDLE, RCAP (capture read data), RRESP (hold R), BRESP (hold B).
- A write is eligible in IDLE when `aw_valid & w_valid`. AW and W are always accepted together; a lone AW or W waits.
- A read is eligible in IDLE when `ar_valid`.
- Grant rule:
  - If only one request type is eligible, it is granted.
  - If both are eligible, the `prio` flag decides (0 = read first). Reset value is 0.
  - After every grant, `prio` points at the other request type.
- Write grant in cycle T:
  - `aw_ready`, `w_ready`, `mem_req_o` and `mem_we_o` are all 1 in cycle T.
  - `mem_addr_o = aw.addr[OFF_W+IDX_W-1:OFF_W]`, `mem_wdata_o = w.data`, `mem_be_o = w.strb`.
  - Next state is BRESP.
- Read grant in cycle T:
  - `ar_ready` and `mem_req_o` are 1 and `mem_we_o` is 0 in cycle T; `mem_addr_o` comes from `ar.addr`.
  - Next state is RCAP.
- RCAP: the R data register is loaded from `mem_rdata_i`; next state is RRESP.
- RRESP: `r_valid=1`, and `r.data` and `r.resp` come from registers. Stay until `r_ready`, then go to IDLE.
- BRESP: `b_valid=1` with the registered `b.resp`. Stay until `b_ready`, then go to IDLE.
- All readies are 0 outside IDLE, so there is one outstanding transaction at most.
- `aw.prot`, `ar.prot` and the address offset bits below `OFF_W` are ignored. Address bits above `OFF_W+IDX_W` are handled as described under Configuration.
- Response on an accepted access: `resp=2'b00` (OKAY).

## Timing
- Write: AW/W handshake at T, `b_valid` at T+1. Best case is 2 cycles per write.
- Read: AR handshake at T, `r_valid` at T+2. Best case is 3 cycles per read.
- Once asserted, `r_valid`/`b_valid` and their payloads stay stable until the corresponding ready is seen.
- Readies may depend combinationally on the request valids. Valids never depend on readies.
- Reset values (while `srst_i=1` and in the cycle after it):
  - All readies, `r_valid`, `b_valid`, `mem_req_o` and `mem_we_o` are 0.
  - `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are 0.
  - R data register = 0, `prio` = 0, state = IDLE.
- `srst_i` mid-transaction (RCAP, RRESP or BRESP): the pending response is dropped and the next cycle is IDLE. A write strobed before reset has already committed to the SRAM.
- `srst_i` has priority over any handshake in the same cycle.

## Configuration
- `AXIL_MEM_CTRL_RANGE_CHECK_EN` defined:
  - Any address with a nonzero bit in `[ADDR_WIDTH-1:OFF_W+IDX_W]` is still handshaked normally.
  - `mem_req_o` stays 0 for that access.
  - The response is `resp=2'b10` (SLVERR); for reads `r.data=0`. Latency is identical to a normal access.
- `AXIL_MEM_CTRL_RANGE_CHECK_EN` undefined:
  - Upper address bits are ignored, so the index wraps modulo `MEM_DEPTH`.
  - The response is always OKAY.

## Test plan
Defaults throughout; the SRAM model applies byte enables.
- Write `0x18` with data `0xDEADBEEF_CAFEF00D`, strb `0xFF`, `b_ready=1` → `mem_addr_o=3` and `mem_we_o=1` at T, `b_valid` with OKAY at T+1. A following read of `0x18` → `r_valid` two cycles after AR with data `0xDEADBEEF_CAFEF00D`.
- Write `0x18` with data `0x11111111_22222222`, strb `0x0F` → `mem_be_o=0x0F`. A read of `0x18` returns `0xDEADBEEF_22222222`.
- Out of reset, AR and AW/W valid in the same cycle → read granted first, write granted after R completes. A second simultaneous pair → write granted first.
- `r_ready` held 0 for 5 cycles in RRESP → `r_valid` and `r.data` stable, all readies 0, no `mem_req_o`.
- Read `0x2000` (index 1024) → with the macro: SLVERR, data 0, no `mem_req_o`. Without the macro: `mem_addr_o=0`, OKAY.
- `srst_i` pulsed during BRESP → `b_valid=0` the next cycle. A subsequent write completes normally with OKAY.
